// File: rtl/sap_clk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sap_clk_pkg : shared state encoding and defaults for the SAP-1 sequencer   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package sap_clk_pkg;

  localparam int STATE_W         = 3;
  localparam int DEFAULT_DIV     = 50_000_000;
  localparam int DEFAULT_DEB_CYC = 500_000;

  typedef enum logic [STATE_W-1:0] {
    ST_PROG   = 3'd0,
    ST_AUTO   = 3'd1,
    ST_MANUAL = 3'd2,
    ST_HALT   = 3'd3
  } sap_state_e;

endpackage
`default_nettype wire

// File: rtl/sap_clock_sequencer_key_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sap_clock_sequencer_key_conditioner : key0 synchroniser, optional debounce |
// | (SAP_DEBOUNCE_EN) and one-cycle rising-edge step request.   Rev 1.0        |
// +----------------------------------------------------------------------------+
module sap_clock_sequencer_key_conditioner
  import sap_clk_pkg::*;
#(
  parameter int DEB_CYC = DEFAULT_DEB_CYC
) (
  input  logic clock_fpga,
  input  logic reset,
  input  logic key0,
  output logic step_req
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic cond;

`ifdef SAP_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             cond_q,    cond_d;

  // Counter runs only while the synchronised level disagrees with the accepted one.
  always_comb begin
    deb_cnt_d = '0;
    cond_d    = cond_q;
    if (sync2_q != cond_q) begin
      if (deb_cnt_q == DEB_LAST) cond_d = sync2_q;
      else                       deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_fpga) begin
    if (reset) begin
      deb_cnt_q <= '0;
      cond_q    <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      cond_q    <= cond_d;
    end
  end

  assign cond = cond_q;
`else
  logic unused_deb_cyc;
  assign unused_deb_cyc = (DEB_CYC != 0);
  assign cond           = sync2_q;
`endif

  always_comb begin
    sync1_d = key0;
    sync2_d = sync1_q;
    prev_d  = cond;
  end

  always_ff @(posedge clock_fpga) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign step_req = cond & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/sap_clock_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sap_clock_sequencer : SAP-1 clock-enable sequencer (auto/manual/halt/prog) |
// | Optional key debounce via SAP_DEBOUNCE_EN.                  Rev 1.0        |
// +----------------------------------------------------------------------------+
module sap_clock_sequencer
  import sap_clk_pkg::*;
#(
  parameter int DIV     = DEFAULT_DIV,
  parameter int DEB_CYC = DEFAULT_DEB_CYC,
  parameter int CNT_W   = 16
) (
  input  logic               clock_fpga,
  input  logic               reset,
  input  logic               prog_run,
  input  logic               selecao_manual_auto,
  input  logic               key0,
  input  logic               hlt_sig,
  output logic               clock_sap_en,
  output logic               clock_sap,
  output logic               halted,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]   tick_cnt
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIV / 2);

  sap_state_e       state_q, state_d;
  logic [DIV_W-1:0] div_q,   div_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             en_q,    en_d;
  logic             sap_q,   sap_d;
  logic             halt_q,  halt_d;
  logic             step_req;

  sap_clock_sequencer_key_conditioner #(
    .DEB_CYC (DEB_CYC)
  ) u_key (
    .clock_fpga (clock_fpga),
    .reset      (reset),
    .key0       (key0),
    .step_req   (step_req)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    sap_d   = 1'b0;
    if (!prog_run) begin
      state_d = ST_PROG;
      div_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_PROG: begin
          state_d = selecao_manual_auto ? ST_AUTO : ST_MANUAL;
          div_d   = '0;
        end
        ST_AUTO: begin
          // Halt and mode change both suppress a coincident divider wrap.
          if (hlt_sig) begin
            state_d = ST_HALT;
          end else if (!selecao_manual_auto) begin
            state_d = ST_MANUAL;
            div_d   = '0;
          end else begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            en_d  = (div_q == DIV_LAST);
            sap_d = (div_q >= DIV_HALF);
          end
        end
        ST_MANUAL: begin
          if (hlt_sig) begin
            state_d = ST_HALT;
          end else if (selecao_manual_auto) begin
            state_d = ST_AUTO;
            div_d   = '0;
          end else begin
            en_d  = step_req;
            sap_d = step_req;
          end
        end
        default: state_d = ST_HALT;
      endcase
      if (en_d && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
    halt_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clock_fpga) begin
    if (reset) begin
      state_q <= ST_PROG;
      div_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      sap_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      sap_q   <= sap_d;
      halt_q  <= halt_d;
    end
  end

  assign clock_sap_en = en_q;
  assign clock_sap    = sap_q;
  assign halted       = halt_q;
  assign state_o      = state_q;
  assign tick_cnt     = cnt_q;

endmodule
`default_nettype wire
